// File: rtl/ara_pkg.sv
// Shared Ara types: pe_req_t payload, VFU ids, PE index offsets.
// pe_target_mask() maps a VFU and the vm bit to the set of PEs to address.
package ara_pkg;

    localparam int unsigned MaxNrLanes = 16;
    localparam int unsigned MaxNrPEs   = MaxNrLanes + 4;

    // Non-lane PEs sit directly above the lanes
    localparam int unsigned OffsetStore = 0;
    localparam int unsigned OffsetLoad  = 1;
    localparam int unsigned OffsetMask  = 2;
    localparam int unsigned OffsetSlide = 3;

    typedef enum logic [2:0] {
        VFU_None,
        VFU_Alu,
        VFU_MFpu,
        VFU_SlideUnit,
        VFU_MaskUnit,
        VFU_LoadUnit,
        VFU_StoreUnit
    } vfu_e;

    typedef enum logic {
        IDLE,
        BCAST
    } bcast_state_e;

    typedef struct packed {
        logic [2:0]  id;
        vfu_e        vfu;
        logic [7:0]  op;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic [4:0]  vd;
        logic        vm;
        logic [15:0] vl;
        logic [15:0] vstart;
    } pe_req_t;

    function automatic logic [MaxNrPEs-1:0] pe_target_mask(
        vfu_e        vfu,
        logic        vm,
        int unsigned nr_lanes
    );
        logic [MaxNrPEs-1:0] one;
        logic [MaxNrPEs-1:0] mask;
        one  = MaxNrPEs'(1);
        mask = '0;
        unique case (vfu)
            VFU_LoadUnit:  mask = one << (nr_lanes + OffsetLoad);
            VFU_StoreUnit: mask = one << (nr_lanes + OffsetStore);
            VFU_SlideUnit: mask = one << (nr_lanes + OffsetSlide);
            VFU_MaskUnit:  mask = one << (nr_lanes + OffsetMask);
            default:       mask = (one << nr_lanes) - one;
        endcase
        if (!vm) begin
            mask = mask | (one << (nr_lanes + OffsetMask));
        end
        return mask;
    endfunction

endpackage

// File: rtl/ara_stall_watchdog.sv
// Stall counter with sticky timeout flag for a pending broadcast.
// Counter saturates at TimeoutCycles; flag rises one cycle after TimeoutCycles-1.
module ara_stall_watchdog #(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy,
    input  logic clear,
    output logic timeout
);

    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);
    localparam logic [CntW-1:0] CntTrip = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] stall_cnt_q;
    logic            timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (!busy || clear) begin
                stall_cnt_q <= '0;
            end else if (stall_cnt_q != CntMax) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (stall_cnt_q == CntTrip) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;

endmodule

// File: rtl/ara_pe_req_broadcast.sv
// Broadcasts one pe_req to a PE subset, tracking per-PE acceptance.
// Optional stall watchdog enabled by define ARA_PE_REQ_TIMEOUT_EN.
module ara_pe_req_broadcast
    import ara_pkg::*;
#(
    parameter int unsigned NrLanes       = 4,
    parameter int unsigned TimeoutCycles = 1024,
    localparam int unsigned NrPEs        = NrLanes + 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  pe_req_t          pe_req_i,
    input  logic [NrPEs-1:0] pe_target_i,
    input  logic             pe_req_valid_i,
    output logic             pe_req_ready_o,
    output pe_req_t          pe_req_o,
    output logic [NrPEs-1:0] pe_req_valid_o,
    input  logic [NrPEs-1:0] pe_req_ready_i,
    output logic             busy_o,
    output logic             stall_timeout_o
);

    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("TimeoutCycles must be at least 2");
    end

    logic [NrPEs-1:0] pending_q;
    logic [NrPEs-1:0] pending_d;
    logic [NrPEs-1:0] pending_next;
    pe_req_t          req_q;
    pe_req_t          req_d;
    logic             upstream_ready;
    logic             accept;
    bcast_state_e     state;

    assign state = (pending_q == '0) ? IDLE : BCAST;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
            req_q     <= '0;
        end else begin
            pending_q <= pending_d;
            req_q     <= req_d;
        end
    end

    // Ready looks through this cycle's PE readys so the slot refills with no bubble
    always_comb begin
        pending_next   = pending_q & ~pe_req_ready_i;
        upstream_ready = (pending_next == '0);
        accept         = pe_req_valid_i && upstream_ready;
        pending_d      = pending_next;
        req_d          = req_q;
        if (accept) begin
            pending_d = pe_target_i;
            req_d     = pe_req_i;
        end
    end

    always_comb begin
        pe_req_ready_o = upstream_ready;
        pe_req_valid_o = pending_q;
        pe_req_o       = req_q;
        busy_o         = (state == BCAST);
    end

`ifdef ARA_PE_REQ_TIMEOUT_EN
    logic handshake;

    assign handshake = |(pending_q & pe_req_ready_i);

    ara_stall_watchdog #(
        .TimeoutCycles(TimeoutCycles)
    ) i_watchdog (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .busy   (busy_o),
        .clear  (handshake),
        .timeout(stall_timeout_o)
    );
`else
    assign stall_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_ara_pe_req_broadcast.sv
// Scenario-driven bench for ara_pe_req_broadcast.
// Accepted payloads go to a scoreboard queue and are popped when broadcast.
module tb_ara_pe_req_broadcast;
    import ara_pkg::*;

    localparam int unsigned NrLanes       = 4;
    localparam int unsigned NrPEs         = NrLanes + 4;
    localparam int unsigned TimeoutCycles = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    pe_req_t          pe_req_i;
    logic [NrPEs-1:0] pe_target_i;
    logic             pe_req_valid_i;
    logic             pe_req_ready_o;
    pe_req_t          pe_req_o;
    logic [NrPEs-1:0] pe_req_valid_o;
    logic [NrPEs-1:0] pe_req_ready_i;
    logic             busy_o;
    logic             stall_timeout_o;

    int      checks = 0;
    int      errors = 0;
    pe_req_t exp_q[$];

    always #5 clk_i = ~clk_i;

    ara_pe_req_broadcast #(
        .NrLanes      (NrLanes),
        .TimeoutCycles(TimeoutCycles)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .pe_req_i       (pe_req_i),
        .pe_target_i    (pe_target_i),
        .pe_req_valid_i (pe_req_valid_i),
        .pe_req_ready_o (pe_req_ready_o),
        .pe_req_o       (pe_req_o),
        .pe_req_valid_o (pe_req_valid_o),
        .pe_req_ready_i (pe_req_ready_i),
        .busy_o         (busy_o),
        .stall_timeout_o(stall_timeout_o)
    );

    initial begin
        #100000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic pe_req_t mk_req();
        pe_req_t r;
        r.id     = 3'($urandom);
        r.vfu    = vfu_e'(3'($urandom_range(0, 6)));
        r.op     = 8'($urandom);
        r.vs1    = 5'($urandom);
        r.vs2    = 5'($urandom);
        r.vd     = 5'($urandom);
        r.vm     = 1'($urandom);
        r.vl     = 16'($urandom);
        r.vstart = 16'($urandom);
        return r;
    endfunction

    task automatic offer(input pe_req_t r, input logic [NrPEs-1:0] t);
        pe_req_i       = r;
        pe_target_i    = t;
        pe_req_valid_i = 1'b1;
    endtask

    task automatic test_reset();
        pe_req_i       = '0;
        pe_target_i    = '0;
        pe_req_valid_i = 1'b0;
        pe_req_ready_i = '0;
        rst_ni         = 1'b1;
        #2 rst_ni      = 1'b0;
        #1;
        checks++;
        if (pe_req_valid_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_valid got %h want 00", pe_req_valid_o);
        end
        checks++;
        if (busy_o !== 1'b0 || pe_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags busy %b ready %b want 0 1",
                     busy_o, pe_req_ready_o);
        end
        checks++;
        if (pe_req_o !== pe_req_t'('0) || stall_timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_payload got %h stall %b want 0 0",
                     pe_req_o, stall_timeout_o);
        end
        #5 rst_ni = 1'b1;
    endtask

    task automatic test_mask_fn();
        logic [MaxNrPEs-1:0] m;
        m = pe_target_mask(VFU_LoadUnit, 1'b1, NrLanes);
        checks++;
        if (m !== 20'h00020) begin
            errors++;
            $display("FAIL mask_load got %h want 00020", m);
        end
        m = pe_target_mask(VFU_StoreUnit, 1'b0, NrLanes);
        checks++;
        if (m !== 20'h00050) begin
            errors++;
            $display("FAIL mask_store_vm0 got %h want 00050", m);
        end
        m = pe_target_mask(VFU_Alu, 1'b0, NrLanes);
        checks++;
        if (m !== 20'h0004F) begin
            errors++;
            $display("FAIL mask_alu_vm0 got %h want 0004F", m);
        end
        m = pe_target_mask(VFU_SlideUnit, 1'b1, NrLanes);
        checks++;
        if (m !== 20'h00080) begin
            errors++;
            $display("FAIL mask_slide got %h want 00080", m);
        end
    endtask

    task automatic test_all_ready();
        pe_req_t r;
        pe_req_t e;
        pe_req_ready_i = 8'hFF;
        tick();
        r = mk_req();
        offer(r, 8'h0F);
        #1;
        checks++;
        if (pe_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL allrdy_up_ready got %b want 1", pe_req_ready_o);
        end
        exp_q.push_back(r);
        tick();
        pe_req_valid_i = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (pe_req_valid_o !== 8'h0F || pe_req_o !== e) begin
            errors++;
            $display("FAIL allrdy_bcast valid %h req %h want 0f %h",
                     pe_req_valid_o, pe_req_o, e);
        end
        checks++;
        if (pe_req_ready_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL allrdy_flags ready %b busy %b want 1 1",
                     pe_req_ready_o, busy_o);
        end
        tick();
        checks++;
        if (pe_req_valid_o !== 8'h00 || busy_o !== 1'b0 ||
            pe_req_o !== e) begin
            errors++;
            $display("FAIL allrdy_done valid %h busy %b req %h want 00 0 %h",
                     pe_req_valid_o, busy_o, pe_req_o, e);
        end
    endtask

    task automatic test_staggered();
        pe_req_t    r;
        pe_req_t    e;
        logic [7:0] m;
        pe_req_ready_i = '0;
        tick();
        r = mk_req();
        offer(r, 8'hFF);
        exp_q.push_back(r);
        tick();
        pe_req_valid_i = 1'b0;
        e = exp_q.pop_front();
        for (int p = 0; p < 8; p++) begin
            pe_req_ready_i = 8'(1 << p);
            #1;
            m = 8'hFF << p;
            checks++;
            if (pe_req_valid_o !== m || pe_req_o !== e) begin
                errors++;
                $display("FAIL stagger_valid p%0d got %h req %h want %h %h",
                         p, pe_req_valid_o, pe_req_o, m, e);
            end
            checks++;
            if (pe_req_ready_o !== (p == 7)) begin
                errors++;
                $display("FAIL stagger_ready p%0d got %b want %b",
                         p, pe_req_ready_o, (p == 7));
            end
            tick();
        end
        pe_req_ready_i = '0;
        checks++;
        if (pe_req_valid_o !== 8'h00 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL stagger_end valid %h busy %b want 00 0",
                     pe_req_valid_o, busy_o);
        end
    endtask

    task automatic test_back_to_back();
        pe_req_t a;
        pe_req_t b;
        pe_req_t e;
        pe_req_ready_i = 8'hFF;
        tick();
        a = mk_req();
        b = mk_req();
        offer(a, 8'h10);
        exp_q.push_back(a);
        tick();
        offer(b, 8'h20);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (pe_req_valid_o !== 8'h10 || pe_req_o !== e) begin
            errors++;
            $display("FAIL b2b_a valid %h req %h want 10 %h",
                     pe_req_valid_o, pe_req_o, e);
        end
        checks++;
        if (pe_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready got %b want 1", pe_req_ready_o);
        end
        exp_q.push_back(b);
        tick();
        pe_req_valid_i = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (pe_req_valid_o !== 8'h20 || pe_req_o !== e) begin
            errors++;
            $display("FAIL b2b_b valid %h req %h want 20 %h",
                     pe_req_valid_o, pe_req_o, e);
        end
        tick();
        checks++;
        if (pe_req_valid_o !== 8'h00) begin
            errors++;
            $display("FAIL b2b_end valid %h want 00", pe_req_valid_o);
        end
    endtask

    task automatic test_zero_target();
        pe_req_t z;
        pe_req_t n;
        pe_req_t e;
        pe_req_ready_i = '0;
        tick();
        z = mk_req();
        n = mk_req();
        offer(z, 8'h00);
        exp_q.push_back(z);
        tick();
        offer(n, 8'h03);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (pe_req_valid_o !== 8'h00 || busy_o !== 1'b0 ||
            pe_req_o !== e) begin
            errors++;
            $display("FAIL zero_bcast valid %h busy %b req %h want 00 0 %h",
                     pe_req_valid_o, busy_o, pe_req_o, e);
        end
        checks++;
        if (pe_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL zero_next_ready got %b want 1", pe_req_ready_o);
        end
        exp_q.push_back(n);
        tick();
        pe_req_valid_i = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (pe_req_valid_o !== 8'h03 || pe_req_o !== e) begin
            errors++;
            $display("FAIL zero_next valid %h req %h want 03 %h",
                     pe_req_valid_o, pe_req_o, e);
        end
        pe_req_ready_i = 8'hFF;
        tick();
        pe_req_ready_i = '0;
    endtask

    task automatic test_hold();
        pe_req_t a;
        pe_req_t b;
        pe_req_t e;
        pe_req_ready_i = '0;
        tick();
        a = mk_req();
        b = mk_req();
        offer(a, 8'h01);
        exp_q.push_back(a);
        tick();
        e = exp_q.pop_front();
        offer(b, 8'hFF);
        #1;
        checks++;
        if (pe_req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_ready got %b want 0", pe_req_ready_o);
        end
        tick();
        checks++;
        if (pe_req_valid_o !== 8'h01 || pe_req_o !== e) begin
            errors++;
            $display("FAIL hold_stable valid %h req %h want 01 %h",
                     pe_req_valid_o, pe_req_o, e);
        end
        pe_req_ready_i = 8'h01;
        #1;
        checks++;
        if (pe_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_release got %b want 1", pe_req_ready_o);
        end
        exp_q.push_back(b);
        tick();
        pe_req_valid_i = 1'b0;
        pe_req_ready_i = '0;
        pe_target_i    = 8'h00;
        e = exp_q.pop_front();
        tick();
        checks++;
        if (pe_req_valid_o !== 8'hFF || pe_req_o !== e) begin
            errors++;
            $display("FAIL hold_next valid %h req %h want ff %h",
                     pe_req_valid_o, pe_req_o, e);
        end
        pe_req_ready_i = 8'hFF;
        tick();
        pe_req_ready_i = '0;
    endtask

    task automatic test_reset_mid();
        pe_req_ready_i = '0;
        tick();
        offer(mk_req(), 8'h0C);
        tick();
        pe_req_valid_i = 1'b0;
        tick();
        checks++;
        if (pe_req_valid_o !== 8'h0C) begin
            errors++;
            $display("FAIL rstmid_pre valid %h want 0c", pe_req_valid_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (pe_req_valid_o !== 8'h00 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async valid %h busy %b want 00 0",
                     pe_req_valid_o, busy_o);
        end
        #2 rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        logic want;
        pe_req_ready_i = '0;
        tick();
        offer(mk_req(), 8'h01);
        tick();
        pe_req_valid_i = 1'b0;
        checks++;
        if (pe_req_valid_o !== 8'h01) begin
            errors++;
            $display("FAIL tmo_valid got %h want 01", pe_req_valid_o);
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
`ifdef ARA_PE_REQ_TIMEOUT_EN
            want = (k >= 16);
`else
            want = 1'b0;
`endif
            checks++;
            if (stall_timeout_o !== want) begin
                errors++;
                $display("FAIL tmo_flag k%0d got %b want %b",
                         k, stall_timeout_o, want);
            end
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (stall_timeout_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_reset stall %b busy %b want 0 0",
                     stall_timeout_o, busy_o);
        end
        #2 rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_mask_fn();
        test_all_ready();
        test_staggered();
        test_back_to_back();
        test_zero_target();
        test_hold();
        test_reset_mid();
        test_timeout();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
